// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: NCH-input registered multiplexer with valid/ready handshake, fixed-select or round-robin.
// Optional MUX_PKT_LOCK_EN adds in_last/out_last and holds the grant for the rest of a packet.
module mux_rr_pipe #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef MUX_PKT_LOCK_EN
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last,
`endif
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;

  logic             w_load_en;
  logic             w_arb_hit;
  logic [SELW-1:0]  w_arb_ch;
  logic             w_grant_hit;
  logic [SELW-1:0]  w_grant_ch;
  logic             w_xfer;
  logic             w_ptr_upd;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [2*NCH-1:0] w_rot;
  logic [SELW:0]    w_sum;

  assign w_load_en = !r_out_valid || out_ready;
  // Rotating the doubled valid vector puts the channel at ptr in bit 0.
  assign w_rot     = {in_valid, in_valid} >> r_ptr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_arb_hit = 1'b0;
    w_arb_ch  = '0;
    w_sum     = '0;
    if (mode) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (w_rot[i]) begin
          w_arb_hit = 1'b1;
          w_sum     = {1'b0, r_ptr} + (SELW + 1)'(i);
          if (w_sum >= (SELW + 1)'(NCH)) w_sum = w_sum - (SELW + 1)'(NCH);
          w_arb_ch  = w_sum[SELW-1:0];
        end
      end
    end else begin
      // Loop compare keeps out-of-range sel values from ever granting.
      for (int k = 0; k < NCH; k++) begin
        if (sel == SELW'(k) && in_valid[k]) begin
          w_arb_hit = 1'b1;
          w_arb_ch  = SELW'(k);
        end
      end
    end
  end

`ifdef MUX_PKT_LOCK_EN
  typedef enum logic {S_IDLE, S_LOCKED} state_t;
  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_lock;
  logic            r_out_last;
  logic            w_last;

  always_comb begin
    w_grant_hit = w_arb_hit;
    w_grant_ch  = w_arb_ch;
    if (r_state == S_LOCKED) begin
      w_grant_ch  = r_lock;
      w_grant_hit = in_valid[r_lock];
    end
  end

  assign w_last = in_last[w_grant_ch];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_xfer && !w_last) w_state_nxt = S_LOCKED;
      S_LOCKED: if (w_xfer && w_last)  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // The pointer advances only when a packet completes, so packets rotate, not beats.
  assign w_ptr_upd = mode && w_xfer && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lock     <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_lock     <= w_grant_ch;
        r_out_last <= w_last;
      end
    end
  end

  assign out_last = r_out_last;
`else
  assign w_grant_hit = w_arb_hit;
  assign w_grant_ch  = w_arb_ch;
  assign w_ptr_upd   = mode && w_xfer;
`endif

  assign w_xfer    = w_grant_hit && w_load_en;
  assign w_ptr_nxt = (w_grant_ch == SELW'(NCH - 1)) ? '0 : w_grant_ch + 1'b1;
  assign in_ready  = (rst_n && w_xfer) ? (NCH'(1) << w_grant_ch) : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else begin
      if (w_ptr_upd) r_ptr <= w_ptr_nxt;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[w_grant_ch*WIDTH +: WIDTH];
        r_out_ch    <= w_grant_ch;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// tb_mux_rr_pipe: directed, table-driven bench for mux_rr_pipe (NCH=4) plus a 3-channel
// instance for out-of-range select and non-power-of-two wrap; packet lock when MUX_PKT_LOCK_EN.
module tb_mux_rr_pipe;
  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]   in_valid, in_ready;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0]  out_ch;
  logic             out_valid, out_ready;

  logic [3*WIDTH-1:0] t_in_data;
  logic [2:0]       t_in_valid, t_in_ready;
  logic             t_mode;
  logic [1:0]       t_sel;
  logic [WIDTH-1:0] t_out_data;
  logic [1:0]       t_out_ch;
  logic             t_out_valid, t_out_ready;

`ifdef MUX_PKT_LOCK_EN
  logic [NCH-1:0] in_last;
  logic           out_last;
  logic [2:0]     t_in_last;
  logic           t_out_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] dat [NCH];
  logic [WIDTH-1:0] tdat [3];

  mux_rr_pipe #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MUX_PKT_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_rr_pipe #(.WIDTH(WIDTH), .NCH(3), .SELW(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(t_in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
`ifdef MUX_PKT_LOCK_EN
    .in_last(t_in_last), .out_last(t_out_last),
`endif
    .mode(t_mode), .sel(t_sel), .out_data(t_out_data), .out_ch(t_out_ch),
    .out_valid(t_out_valid), .out_ready(t_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    dat[0] = 32'hAAAA_AAAA; dat[1] = 32'h5555_5555; dat[2] = 32'hC3C3_C3C3; dat[3] = 32'h0F0F_0F0F;
    tdat[0] = 32'h1111_1111; tdat[1] = 32'h2222_2222; tdat[2] = 32'h3333_3333;
    in_data   = {dat[3], dat[2], dat[1], dat[0]};
    t_in_data = {tdat[2], tdat[1], tdat[0]};

    //             mode  sel   valid    ordy  exp_rdy  ov    ch
    vecs[0]  = '{1'b0, 2'd1, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[1]  = '{1'b0, 2'd1, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[8]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[9]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[14] = '{1'b0, 2'd2, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[15] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[16] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[17] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[18] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};

    rst_n = 1'b0;
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0011; out_ready = 1'b1;
    t_mode = 1'b0; t_sel = 2'd0; t_in_valid = 3'b000; t_out_ready = 1'b1;
`ifdef MUX_PKT_LOCK_EN
    in_last = '1; t_in_last = '1;
`endif
    #7;
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_ch", 64'(out_ch), 64'h0);
    #5 rst_n = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel; in_valid = vecs[i].valid; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
      step();
      check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      check($sformatf("v%0d_out_ch", i), 64'(out_ch), 64'(vecs[i].exp_ch));
      check($sformatf("v%0d_out_data", i), 64'(out_data), 64'(dat[vecs[i].exp_ch]));
    end

    // Async reset mid-stream: ptr is 2 when reset hits, so the next grant proves it restarted at 0.
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    step();
    check("pre_rst_ch0", 64'(out_ch), 64'd0);
    step();
    check("pre_rst_ch1", 64'(out_ch), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'h0);
    check("arst_out_data", 64'(out_data), 64'h0);
    check("arst_out_ch", 64'(out_ch), 64'h0);
    check("arst_in_ready", 64'(in_ready), 64'h0);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_valid", 64'(out_valid), 64'h1);
    check("post_rst_ch", 64'(out_ch), 64'd0);
    check("post_rst_data", 64'(out_data), 64'(dat[0]));
    in_valid = 4'b0000;

    // 3-channel instance: sel=3 is out of range; round-robin wraps from ch2 to ch0.
    t_mode = 1'b0; t_sel = 2'd1; t_in_valid = 3'b111; t_out_ready = 1'b1;
    #1;
    check("n3_sel1_ready", 64'(t_in_ready), 64'b010);
    step();
    check("n3_sel1_valid", 64'(t_out_valid), 64'h1);
    check("n3_sel1_data", 64'(t_out_data), 64'(tdat[1]));
    t_sel = 2'd3;
    #1;
    check("n3_sel3_ready", 64'(t_in_ready), 64'b000);
    step();
    check("n3_sel3_drain", 64'(t_out_valid), 64'h0);
    check("n3_sel3_hold_ch", 64'(t_out_ch), 64'd1);
    t_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("n3_rr%0d_ready", i), 64'(t_in_ready), 64'(3'b001 << (i % 3)));
      step();
      check($sformatf("n3_rr%0d_ch", i), 64'(t_out_ch), 64'(i % 3));
      check($sformatf("n3_rr%0d_data", i), 64'(t_out_data), 64'(tdat[i % 3]));
    end
    t_in_valid = 3'b000;

`ifdef MUX_PKT_LOCK_EN
    // Packet lock: ch2 sends a 3-beat packet while ch0 stays valid; mode flips to fixed sel=0 mid-packet.
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    mode = 1'b1; in_valid = 4'b0101; in_last = 4'b1011; out_ready = 1'b1;
    #1;
    check("lk0_ready", 64'(in_ready), 64'b0001);
    step();
    check("lk0_ch", 64'(out_ch), 64'd0);
    check("lk0_last", 64'(out_last), 64'h1);
    #1;
    check("lk1_ready", 64'(in_ready), 64'b0100);
    step();
    check("lk1_ch", 64'(out_ch), 64'd2);
    check("lk1_last", 64'(out_last), 64'h0);
    mode = 1'b0; sel = 2'd0;
    #1;
    check("lk2_ready", 64'(in_ready), 64'b0100);
    step();
    check("lk2_ch", 64'(out_ch), 64'd2);
    check("lk2_last", 64'(out_last), 64'h0);
    in_last = 4'b1111;
    #1;
    check("lk3_ready", 64'(in_ready), 64'b0100);
    step();
    check("lk3_ch", 64'(out_ch), 64'd2);
    check("lk3_last", 64'(out_last), 64'h1);
    #1;
    check("lk4_ready", 64'(in_ready), 64'b0001);
    step();
    check("lk4_ch", 64'(out_ch), 64'd0);
    mode = 1'b1;
    #1;
    check("lk5_ready", 64'(in_ready), 64'b0100);
    step();
    check("lk5_ch", 64'(out_ch), 64'd2);
    in_valid = 4'b0000;
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
